// File: rtl/stack_sequencer.sv
// Stack sequencer: walks decoded push/pop masks, issuing one 16-bit stack bus transfer per set bit.
// Pushes run lowest bit first, pops highest bit first, and every push finishes before the first pop.
module stack_sequencer #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       push_mask,
  input  logic [15:0]       pop_mask,
  input  logic [15:0]       sp_in,
  input  logic [15:0]       ss_in,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sp_out,
  output logic [3:0]        rd_sel,
  input  logic [15:0]       rd_data,
  output logic              wb_valid,
  output logic [3:0]        wb_sel,
  output logic [15:0]       wb_data,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [15:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [15:0]       bus_rdata
);
  localparam logic [3:0] SP_IDX = 4'd4;

  typedef enum logic [1:0] {IDLE, PUSH, POP, DONE} state_t;

  state_t            r_state, w_next;
  logic [15:0]       r_push, r_pop, r_sp_w, r_ss_w, r_sp_out, r_wdata, r_wb_data;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_wb_sel;
  logic              r_busy, r_done, r_req, r_wr, r_wb_valid;
  logic [3:0]        w_push_n, w_pop_n;
  logic [15:0]       w_push_rest, w_pop_rest, w_sp_dec;
  logic              w_ack, w_accept;

  function automatic logic [3:0] lowest_bit(input logic [15:0] m);
    lowest_bit = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (m[i]) lowest_bit = 4'(i);
  endfunction

  function automatic logic [3:0] highest_bit(input logic [15:0] m);
    highest_bit = 4'd0;
    for (int i = 0; i < 16; i++)
      if (m[i]) highest_bit = 4'(i);
  endfunction

  function automatic logic [ADDR_W-1:0] phys(input logic [15:0] seg, input logic [15:0] off);
    phys = ADDR_W'({seg, 4'h0}) + ADDR_W'(off);
  endfunction

  assign w_push_n    = lowest_bit(r_push);
  assign w_pop_n     = highest_bit(r_pop);
  assign w_push_rest = r_push & ~(16'd1 << w_push_n);
  assign w_pop_rest  = r_pop & ~(16'd1 << w_pop_n);
  assign w_sp_dec    = r_sp_w - 16'd2;
  assign w_ack       = r_req & bus_ack;
  assign w_accept    = start & ~r_busy & (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
        if (push_mask != 16'd0)     w_next = PUSH;
        else if (pop_mask != 16'd0) w_next = POP;
        else                        w_next = DONE;
      end
      PUSH: if (w_ack) begin
        if (w_push_rest != 16'd0) w_next = PUSH;
        else if (r_pop != 16'd0)  w_next = POP;
        else                      w_next = DONE;
      end
      POP: if (w_ack) begin
        if (w_pop_rest != 16'd0) w_next = POP;
        else                     w_next = DONE;
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Each transfer is a setup cycle (bus_req low, outputs loaded) followed by a held
  // request until ack; the setup cycle doubles as the mandatory gap between transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_push     <= 16'd0;
      r_pop      <= 16'd0;
      r_sp_w     <= 16'd0;
      r_ss_w     <= 16'd0;
      r_sp_out   <= 16'd0;
      r_wdata    <= 16'd0;
      r_wb_data  <= 16'd0;
      r_wb_sel   <= 4'd0;
      r_addr     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_req      <= 1'b0;
      r_wr       <= 1'b0;
      r_wb_valid <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_wb_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (start) begin
            r_push <= push_mask;
            r_pop  <= pop_mask;
            r_sp_w <= sp_in;
            r_ss_w <= ss_in;
            r_busy <= 1'b1;
          end
        end
        PUSH: begin
          if (!r_req) begin
            r_sp_w  <= w_sp_dec;
            r_req   <= 1'b1;
            r_wr    <= 1'b1;
            r_addr  <= phys(r_ss_w, w_sp_dec);
            r_wdata <= (w_push_n == SP_IDX) ? w_sp_dec : rd_data;
          end else if (bus_ack) begin
            r_req  <= 1'b0;
            r_push <= w_push_rest;
          end
        end
        POP: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_wr   <= 1'b0;
            r_addr <= phys(r_ss_w, r_sp_w);
          end else if (bus_ack) begin
            r_req      <= 1'b0;
            r_pop      <= w_pop_rest;
            r_wb_valid <= 1'b1;
            r_wb_sel   <= w_pop_n;
            r_wb_data  <= bus_rdata;
            r_sp_w     <= (w_pop_n == SP_IDX) ? bus_rdata : r_sp_w + 16'd2;
          end
        end
        DONE: begin
          r_done   <= 1'b1;
          r_sp_out <= r_sp_w;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sp_out    = r_sp_out;
  assign rd_sel    = (r_state == PUSH) ? w_push_n : 4'd0;
  assign wb_valid  = r_wb_valid;
  assign wb_sel    = r_wb_sel;
  assign wb_data   = r_wb_data;
  assign bus_req   = r_req;
  assign bus_wr    = r_wr;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: directed and randomized mask sequences against a transfer-list model
// with a randomly delayed bus responder and a combinational register file.
module tb_stack_sequencer;
  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [15:0]       push_mask, pop_mask, sp_in, ss_in;
  logic              busy, done;
  logic [15:0]       sp_out;
  logic [3:0]        rd_sel;
  logic [15:0]       rd_data;
  logic              wb_valid;
  logic [3:0]        wb_sel;
  logic [15:0]       wb_data;
  logic              bus_req, bus_wr;
  logic [ADDR_W-1:0] bus_addr;
  logic [15:0]       bus_wdata;
  logic              bus_ack;
  logic [15:0]       bus_rdata;

  stack_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .push_mask(push_mask), .pop_mask(pop_mask), .sp_in(sp_in), .ss_in(ss_in),
    .busy(busy), .done(done), .sp_out(sp_out),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  logic [15:0] regs [16];
  assign rd_data = regs[rd_sel];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic [19:0] addr;
    logic [15:0] data;
    logic [3:0]  sel;
  } xfer_t;

  logic [15:0] rd_script[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] phys(input logic [15:0] seg, input logic [15:0] off);
    phys = {seg, 4'h0} + {4'h0, off};
  endfunction

  task automatic fill_regs();
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
  endtask

  task automatic run_seq(input string name, input logic [15:0] pm, input logic [15:0] qm,
                         input logic [15:0] sp0, input logic [15:0] ss0, input int maxd,
                         input bit poke, input bit chk_sp, input logic [15:0] want_sp);
    xfer_t       q[$];
    xfer_t       wbq[$];
    xfer_t       cur, e;
    logic [15:0] sp, d;
    logic [19:0] h_addr;
    logic        h_wr;
    logic [15:0] h_wdata;
    bit          in_xfer, ack_last, saw_done, finished;
    int          wait_n;
    in_xfer = 0; ack_last = 0; saw_done = 0; finished = 0; wait_n = 0;
    cur = '{wr: 1'b0, addr: 20'h0, data: 16'h0, sel: 4'h0};

    // Expected transfer list straight from the mask rules.
    sp = sp0;
    for (int n = 0; n < 16; n++) if (pm[n]) begin
      sp = sp - 16'd2;
      q.push_back('{wr: 1'b1, addr: phys(ss0, sp), data: (n == 4) ? sp : regs[n], sel: 4'(n)});
    end
    for (int n = 15; n >= 0; n--) if (qm[n]) begin
      if (rd_script.size() > 0) d = rd_script.pop_front();
      else                      d = 16'($urandom);
      q.push_back('{wr: 1'b0, addr: phys(ss0, sp), data: d, sel: 4'(n)});
      sp = (n == 4) ? d : sp + 16'd2;
    end

    @(negedge clk);
    start = 1'b1; push_mask = pm; pop_mask = qm; sp_in = sp0; ss_in = ss0;
    for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = poke;
        push_mask = 16'($urandom) | 16'h0001; pop_mask = 16'($urandom);
        sp_in = 16'($urandom); ss_in = 16'($urandom);
        chk({name, ".busy_run"}, 32'(busy), 32'd1);
      end else begin
        start = 1'b0;
      end

      if (saw_done) begin
        chk({name, ".busy_after"}, 32'(busy), 32'd0);
        chk({name, ".done_pulse"}, 32'(done), 32'd0);
        finished = 1;
      end else if (done) begin
        chk({name, ".sp_out"}, 32'(sp_out), 32'(sp));
        if (chk_sp) chk({name, ".sp_out_const"}, 32'(sp_out), 32'(want_sp));
        chk({name, ".busy_at_done"}, 32'(busy), 32'd1);
        chk({name, ".left_xfers"}, 32'(q.size() + wbq.size()), 32'd0);
        if (pm == 16'd0 && qm == 16'd0) chk({name, ".done_latency"}, 32'(cyc), 32'd2);
        saw_done = 1;
      end

      if (wb_valid) begin
        if (wbq.size() == 0) chk({name, ".wb_extra"}, 32'd1, 32'd0);
        else begin
          e = wbq.pop_front();
          chk({name, ".wb_sel"}, 32'(wb_sel), 32'(e.sel));
          chk({name, ".wb_data"}, 32'(wb_data), 32'(e.data));
        end
      end

      bus_ack = 1'b0;
      if (ack_last) begin
        chk({name, ".req_gap"}, 32'(bus_req), 32'd0);
        ack_last = 0;
      end else if (bus_req) begin
        if (!in_xfer) begin
          in_xfer = 1;
          wait_n = $urandom_range(0, maxd);
          if (q.size() == 0) begin
            chk({name, ".extra_xfer"}, 32'd1, 32'd0);
            cur = '{wr: bus_wr, addr: bus_addr, data: bus_wdata, sel: 4'h0};
          end else begin
            cur = q.pop_front();
          end
          h_wr = bus_wr; h_addr = bus_addr; h_wdata = bus_wdata;
          chk({name, ".bus_wr"}, 32'(bus_wr), 32'(cur.wr));
          chk({name, ".bus_addr"}, 32'(bus_addr), 32'(cur.addr));
          if (cur.wr) chk({name, ".bus_wdata"}, 32'(bus_wdata), 32'(cur.data));
        end else begin
          chk({name, ".hold"},
              32'((bus_wr !== h_wr) || (bus_addr !== h_addr) || (bus_wdata !== h_wdata)), 32'd0);
        end
        if (wait_n == 0) begin
          bus_ack = 1'b1;
          bus_rdata = cur.wr ? 16'($urandom) : cur.data;
          ack_last = 1; in_xfer = 0;
          if (!cur.wr) wbq.push_back(cur);
        end else begin
          wait_n--;
        end
      end else begin
        bus_ack = ($urandom_range(0, 3) == 0);
        bus_rdata = 16'($urandom);
      end
    end
    if (!finished) chk({name, ".timeout"}, 32'd0, 32'd1);
    start = 1'b0; bus_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk({name, ".quiet"}, 32'({bus_req, busy, done, wb_valid}), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; push_mask = '0; pop_mask = '0; sp_in = '0; ss_in = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    fill_regs();
    repeat (2) @(negedge clk);
    chk("rst.ctrl", 32'({busy, done, wb_valid, bus_req, bus_wr}), 32'd0);
    chk("rst.sp_out", 32'(sp_out), 32'd0);
    chk("rst.bus_addr", 32'(bus_addr), 32'd0);
    chk("rst.bus_wdata", 32'(bus_wdata), 32'd0);
    chk("rst.wb", 32'({wb_sel, wb_data}), 32'd0);
    chk("rst.rd_sel", 32'(rd_sel), 32'd0);
    reset = 1'b0;

    regs[0] = 16'h1234;
    run_seq("push_aw", 16'h0001, 16'h0000, 16'h0100, 16'h2000, 2, 0, 1, 16'h00FE);
    fill_regs();
    run_seq("push_call", 16'h2400, 16'h0000, 16'h0000, 16'hF000, 3, 0, 1, 16'hFFFC);
    rd_script = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    run_seq("pop_reti", 16'h0000, 16'h2600, 16'h0010, 16'h0000, 2, 0, 1, 16'h0016);
    run_seq("push_sp", 16'h0010, 16'h0000, 16'h0050, 16'h1000, 1, 1, 1, 16'h004E);
    rd_script = '{16'h9000};
    run_seq("pop_sp", 16'h0000, 16'h0010, 16'h0200, 16'h1000, 1, 0, 1, 16'h9000);
    run_seq("empty", 16'h0000, 16'h0000, 16'h4321, 16'h0ABC, 1, 1, 1, 16'h4321);
    fill_regs();
    run_seq("both", 16'hE00F, 16'hC013, 16'h0003, 16'hFFFF, 3, 1, 0, 16'h0000);

    // Reset while a push request is outstanding.
    fill_regs();
    @(negedge clk);
    start = 1'b1; push_mask = 16'h0003; pop_mask = 16'h0000; sp_in = 16'h0400; ss_in = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !bus_req; i++) @(negedge clk);
    chk("rstmid.req_seen", 32'(bus_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid.bus_req", 32'(bus_req), 32'd0);
    chk("rstmid.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    run_seq("after_rst", 16'h0006, 16'h0001, 16'h0400, 16'h0100, 2, 0, 0, 16'h0000);

    for (int t = 0; t < 24; t++) begin
      fill_regs();
      run_seq("rand", 16'($urandom) & 16'($urandom), 16'($urandom) & 16'($urandom),
              16'($urandom), 16'($urandom), 3, bit'($urandom_range(0, 1)), 0, 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
